// File: rtl/sub_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding and default width.
package sub_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int SUB_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the bit-serial subtractor; the master issues operands, the slave computes.
interface serial_subtractor_if
   import sub_pkg::*;
   #(parameter int WIDTH = SUB_WIDTH);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (output start, a, b, input busy, done, diff, bout);
   modport slave  (input start, a, b, output busy, done, diff, bout);

endinterface

// File: rtl/fullsubtractor.sv
// Single-bit full subtractor cell: diff = a - b - bin, bout set when the bit underflows.
module fullsubtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one fullsubtractor cell, LSB first, borrow closed through a flop.
module serial_subtractor
   import sub_pkg::*;
   #(parameter int WIDTH = SUB_WIDTH)
(
   input  logic clk,
   input  logic rst,
   serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   sub_state_t       state;
   sub_state_t       state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Only the upper WIDTH-1 result bits are kept; the LSB is shifted out on the final edge.
   logic [WIDTH-2:0] d_sh;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;

   logic             cell_diff;
   logic             cell_bout;
   logic             last_bit;
   logic [WIDTH-1:0] d_next;

   fullsubtractor u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (brw),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));
   assign d_next   = {cell_diff, d_sh};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SHIFT;
         SHIFT:   if (last_bit)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Results are published only on the last shift edge so partial sums never reach the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         d_sh   <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         diff_r <= '0;
         bout_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh <= bus.a;
                  b_sh <= bus.b;
                  brw  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sh <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh <= {1'b0, b_sh[WIDTH-1:1]};
               d_sh <= d_next[WIDTH-1:1];
               brw  <= cell_bout;
               cnt  <= cnt + 1'b1;
               if (last_bit) begin
                  diff_r <= d_next;
                  bout_r <= cell_bout;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state == SHIFT);
   assign bus.done = (state == DONE);
   assign bus.diff = diff_r;
   assign bus.bout = bout_r;

endmodule
